// File: rtl/pcie_datalink_pkg.sv
// Data-link-layer types shared by the flow-control transmit and receive blocks:
// DLLP type codes, FC credit classes, DLLP field layout and credit accessors.
package pcie_datalink_pkg;

  // Smallest header credit count the transmit side will advertise.
  localparam int unsigned HdrMinCredits = 1;

  // Upper nibble of DLLP byte 0 for the flow-control DLLPs.
  typedef enum logic [3:0] {
    InitFC1_P    = 4'h4,
    InitFC1_NP   = 4'h5,
    InitFC1_CPL  = 4'h6,
    UpdateFC_P   = 4'h8,
    UpdateFC_NP  = 4'h9,
    UpdateFC_CPL = 4'hA,
    InitFC2_P    = 4'hC,
    InitFC2_NP   = 4'hD,
    InitFC2_CPL  = 4'hE
  } dllp_type_e;

  typedef enum logic [1:0] {
    FC_P   = 2'd0,
    FC_NP  = 2'd1,
    FC_CPL = 2'd2
  } fc_type_e;

  typedef enum logic [1:0] {
    RX_HDR   = 2'd0,
    RX_CRC   = 2'd1,
    RX_DRAIN = 2'd2
  } rx_state_e;

  typedef enum logic [1:0] {
    FC_INIT1 = 2'd0,
    FC_INIT2 = 2'd1,
    FC_DONE  = 2'd2
  } fc_state_e;

  // First DLLP beat as received: byte 0 sits in the low bits.
  typedef struct packed {
    logic [7:0] byte3;
    logic [7:0] byte2;
    logic [7:0] byte1;
    logic [3:0] kind;
    logic       rsvd;
    logic [2:0] vc;
  } dllp_fc_t;

  function automatic logic [7:0] fc_hdr(input dllp_fc_t d);
    return {d.byte1[5:0], d.byte2[7:6]};
  endfunction

  function automatic logic [11:0] fc_data(input dllp_fc_t d);
    return {d.byte2[3:0], d.byte3};
  endfunction

endpackage

// File: rtl/pcie_datalink_crc.sv
// DLLP CRC-16 (polynomial 0x100B) over one 32-bit beat, byte 0 first, bit 0 of
// each byte first. Purely combinational.
module pcie_datalink_crc (
  input  logic [31:0] data,
  input  logic [15:0] crc_in,
  output logic [15:0] crc_out
);

  logic [15:0] acc;

  always_comb begin
    acc = crc_in;
    for (int i = 0; i < 32; i++) begin
      if (acc[15] ^ data[i]) begin
        acc = {acc[14:0], 1'b0} ^ 16'h100B;
      end else begin
        acc = {acc[14:0], 1'b0};
      end
    end
    crc_out = acc;
  end

endmodule

// File: rtl/pcie_flow_ctrl_rx.sv
// Receive-side flow-control: checks DLLP CRC, decodes InitFC1/InitFC2/UpdateFC
// for VC0 and latches partner credits. Optional stats via PCIE_FC_RX_STATS_EN.
module pcie_flow_ctrl_rx
  import pcie_datalink_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 3
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  dl_down_i,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic [USER_WIDTH-1:0] s_axis_tuser,
  output logic                  s_axis_tready,
  output logic                  fc1_values_stored_o,
  output logic                  fc2_values_stored_o,
  output logic [7:0]            p_hdr_o,
  output logic [7:0]            np_hdr_o,
  output logic [7:0]            cpl_hdr_o,
  output logic [11:0]           p_data_o,
  output logic [11:0]           np_data_o,
  output logic [11:0]           cpl_data_o,
  output logic                  update_valid_o,
  output logic [1:0]            update_type_o,
  output logic                  crc_err_o
`ifdef PCIE_FC_RX_STATS_EN
  ,
  output logic [15:0]           crc_err_cnt_o,
  output logic [15:0]           drop_cnt_o
`endif
);

  // Handshake: a beat transfers on a rising edge where s_axis_tvalid and
  // s_axis_tready are both high; tready is held high whenever out of reset.
  logic        tready_q;
  logic        beat_ok;

  rx_state_e   rx_state_q, rx_state_d;
  fc_state_e   fc_state_q, fc_state_d;

  dllp_fc_t    hdr_q;
  logic        hdr_bad_q;
  logic        done_q, tail_bad_q, err_q;
  logic [15:0] crc_rx_q;
  logic        load_hdr, done_d, err_d;

  logic [15:0] crc_calc, crc_exp;
  logic        crc_ok, good, crc_err_d;

  logic        is_init1, is_init2, is_update;
  logic [1:0]  fc_idx;
  logic [2:0]  seen_q, seen_d;
  logic        fc1_d, fc2_d, store, upd_d, drop;

  logic [7:0]  hdr_cr_q  [3];
  logic [11:0] data_cr_q [3];

  logic        unused_ok;
  assign unused_ok = ^{s_axis_tuser, s_axis_tdata[DATA_WIDTH-1:16]};

  assign beat_ok       = s_axis_tvalid && tready_q;
  assign s_axis_tready = tready_q;

  pcie_datalink_crc u_crc (
    .data    (hdr_q),
    .crc_in  (16'hFFFF),
    .crc_out (crc_calc)
  );

  // The transmitter sends the CRC inverted and byte-swapped.
  assign crc_exp   = {~crc_calc[7:0], ~crc_calc[15:8]};
  assign crc_ok    = done_q && !tail_bad_q && (crc_rx_q == crc_exp);
  assign good      = crc_ok && !dl_down_i;
  assign crc_err_d = !dl_down_i && (err_q || (done_q && !crc_ok));
  assign fc_idx    = hdr_q.kind[1:0];

  always_comb begin
    rx_state_d = rx_state_q;
    load_hdr   = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    if (beat_ok) begin
      case (rx_state_q)
        RX_HDR: begin
          if (s_axis_tlast) begin
            err_d = 1'b1;
          end else begin
            load_hdr   = 1'b1;
            rx_state_d = RX_CRC;
          end
        end
        RX_CRC: begin
          if (s_axis_tlast) begin
            done_d     = 1'b1;
            rx_state_d = RX_HDR;
          end else begin
            err_d      = 1'b1;
            rx_state_d = RX_DRAIN;
          end
        end
        RX_DRAIN: begin
          if (s_axis_tlast) rx_state_d = RX_HDR;
        end
        default: rx_state_d = RX_HDR;
      endcase
    end
  end

  always_comb begin
    fc_state_d = fc_state_q;
    seen_d     = seen_q;
    fc1_d      = fc1_values_stored_o;
    fc2_d      = fc2_values_stored_o;
    store      = 1'b0;
    upd_d      = 1'b0;
    drop       = 1'b0;
    is_init1   = 1'b0;
    is_init2   = 1'b0;
    is_update  = 1'b0;
    case (hdr_q.kind)
      InitFC1_P, InitFC1_NP, InitFC1_CPL:    is_init1  = 1'b1;
      InitFC2_P, InitFC2_NP, InitFC2_CPL:    is_init2  = 1'b1;
      UpdateFC_P, UpdateFC_NP, UpdateFC_CPL: is_update = 1'b1;
      default: ;
    endcase
    if (dl_down_i) begin
      fc_state_d = FC_INIT1;
      seen_d     = 3'b000;
      fc1_d      = 1'b0;
      fc2_d      = 1'b0;
    end else if (good) begin
      if (hdr_q.vc != 3'd0 || !(is_init1 || is_init2 || is_update)) begin
        drop = 1'b1;
      end else begin
        case (fc_state_q)
          FC_INIT1: begin
            if (is_update) begin
              drop = 1'b1;
            end else begin
              store  = 1'b1;
              seen_d = seen_q | (3'b001 << fc_idx);
              if (&seen_d) begin
                fc1_d      = 1'b1;
                fc_state_d = FC_INIT2;
              end
            end
          end
          FC_INIT2: begin
            if (is_init1) begin
              drop = 1'b1;
            end else begin
              fc2_d      = 1'b1;
              fc_state_d = FC_DONE;
            end
          end
          FC_DONE: begin
            if (is_update) begin
              store = 1'b1;
              upd_d = 1'b1;
            end else begin
              drop = 1'b1;
            end
          end
          default: fc_state_d = FC_INIT1;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      tready_q            <= 1'b0;
      rx_state_q          <= RX_HDR;
      fc_state_q          <= FC_INIT1;
      hdr_q               <= '0;
      hdr_bad_q           <= 1'b0;
      done_q              <= 1'b0;
      tail_bad_q          <= 1'b0;
      err_q               <= 1'b0;
      crc_rx_q            <= '0;
      seen_q              <= '0;
      fc1_values_stored_o <= 1'b0;
      fc2_values_stored_o <= 1'b0;
      update_valid_o      <= 1'b0;
      update_type_o       <= '0;
      crc_err_o           <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        hdr_cr_q[i]  <= '0;
        data_cr_q[i] <= '0;
      end
    end else begin
      tready_q            <= 1'b1;
      rx_state_q          <= rx_state_d;
      fc_state_q          <= fc_state_d;
      seen_q              <= seen_d;
      fc1_values_stored_o <= fc1_d;
      fc2_values_stored_o <= fc2_d;
      update_valid_o      <= upd_d;
      crc_err_o           <= crc_err_d;
      // A DLLP finishing while the link is down never reaches the decode stage.
      done_q              <= done_d && !dl_down_i;
      err_q               <= err_d && !dl_down_i;
      if (load_hdr) begin
        hdr_q     <= s_axis_tdata;
        hdr_bad_q <= (s_axis_tkeep != 4'hF);
      end
      if (done_d) begin
        crc_rx_q   <= s_axis_tdata[15:0];
        tail_bad_q <= hdr_bad_q || (s_axis_tkeep != 4'h3);
      end
      if (upd_d) update_type_o <= fc_idx;
      if (dl_down_i) begin
        for (int i = 0; i < 3; i++) begin
          hdr_cr_q[i]  <= '0;
          data_cr_q[i] <= '0;
        end
      end else if (store) begin
        hdr_cr_q[fc_idx]  <= fc_hdr(hdr_q);
        data_cr_q[fc_idx] <= fc_data(hdr_q);
      end
    end
  end

  assign p_hdr_o    = hdr_cr_q[FC_P];
  assign np_hdr_o   = hdr_cr_q[FC_NP];
  assign cpl_hdr_o  = hdr_cr_q[FC_CPL];
  assign p_data_o   = data_cr_q[FC_P];
  assign np_data_o  = data_cr_q[FC_NP];
  assign cpl_data_o = data_cr_q[FC_CPL];

`ifdef PCIE_FC_RX_STATS_EN
  logic [15:0] crc_err_cnt_q, drop_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i || dl_down_i) begin
      crc_err_cnt_q <= '0;
      drop_cnt_q    <= '0;
    end else begin
      if (crc_err_d && crc_err_cnt_q != 16'hFFFF) crc_err_cnt_q <= crc_err_cnt_q + 16'd1;
      if (drop && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign crc_err_cnt_o = crc_err_cnt_q;
  assign drop_cnt_o    = drop_cnt_q;
`endif

endmodule

// File: tb/tb_pcie_flow_ctrl_rx.sv
// Bench for pcie_flow_ctrl_rx: directed FC init scenarios plus randomized DLLP
// streams checked against a flag-based behavioural model and byte-wise CRC.
`timescale 1ns/1ps
module tb_pcie_flow_ctrl_rx;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        dl_down;
  logic [31:0] s_axis_tdata;
  logic [3:0]  s_axis_tkeep;
  logic        s_axis_tvalid;
  logic        s_axis_tlast;
  logic [2:0]  s_axis_tuser;
  logic        s_axis_tready;
  logic        fc1_values_stored_o, fc2_values_stored_o;
  logic [7:0]  p_hdr_o, np_hdr_o, cpl_hdr_o;
  logic [11:0] p_data_o, np_data_o, cpl_data_o;
  logic        update_valid_o;
  logic [1:0]  update_type_o;
  logic        crc_err_o;
`ifdef PCIE_FC_RX_STATS_EN
  logic [15:0] crc_err_cnt, drop_cnt;
`endif

  pcie_flow_ctrl_rx dut (
    .clk_i               (clk),
    .rst_n_i             (rst_n),
    .dl_down_i           (dl_down),
    .s_axis_tdata        (s_axis_tdata),
    .s_axis_tkeep        (s_axis_tkeep),
    .s_axis_tvalid       (s_axis_tvalid),
    .s_axis_tlast        (s_axis_tlast),
    .s_axis_tuser        (s_axis_tuser),
    .s_axis_tready       (s_axis_tready),
    .fc1_values_stored_o (fc1_values_stored_o),
    .fc2_values_stored_o (fc2_values_stored_o),
    .p_hdr_o             (p_hdr_o),
    .np_hdr_o            (np_hdr_o),
    .cpl_hdr_o           (cpl_hdr_o),
    .p_data_o            (p_data_o),
    .np_data_o           (np_data_o),
    .cpl_data_o          (cpl_data_o),
    .update_valid_o      (update_valid_o),
    .update_type_o       (update_type_o),
    .crc_err_o           (crc_err_o)
`ifdef PCIE_FC_RX_STATS_EN
    ,
    .crc_err_cnt_o       (crc_err_cnt),
    .drop_cnt_o          (drop_cnt)
`endif
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int crc_err_seen = 0;
  int upd_seen     = 0;

  // ---------------- reference model ----------------
  logic [1:0]  exp_q[$];
  logic [7:0]  m_hdr  [3];
  logic [11:0] m_data [3];
  logic [2:0]  m_seen;
  logic        m_fc1, m_fc2;
  logic [1:0]  mon_exp;

  function automatic void model_clear();
    for (int i = 0; i < 3; i++) begin
      m_hdr[i]  = '0;
      m_data[i] = '0;
    end
    m_seen = '0;
    m_fc1  = 1'b0;
    m_fc2  = 1'b0;
  endfunction

  // class: 1 = InitFC1, 2 = InitFC2, 3 = UpdateFC, 0 = anything else
  function automatic void model_apply(input logic [3:0] kind, input logic [2:0] vc,
                                      input logic [7:0] h, input logic [11:0] d);
    int cls;
    logic [1:0] t;
    t = kind[1:0];
    case (kind)
      4'h4, 4'h5, 4'h6: cls = 1;
      4'hC, 4'hD, 4'hE: cls = 2;
      4'h8, 4'h9, 4'hA: cls = 3;
      default:          cls = 0;
    endcase
    if (vc != 3'd0 || cls == 0) return;
    if (!m_fc1) begin
      if (cls != 3) begin
        m_hdr[t]  = h;
        m_data[t] = d;
        m_seen[t] = 1'b1;
        if (m_seen == 3'b111) m_fc1 = 1'b1;
      end
    end else if (!m_fc2) begin
      if (cls != 1) m_fc2 = 1'b1;
    end else if (cls == 3) begin
      m_hdr[t]  = h;
      m_data[t] = d;
      exp_q.push_back(t);
    end
  endfunction

  function automatic logic [61:0] model_vec();
    return {m_fc1, m_fc2, m_hdr[0], m_data[0], m_hdr[1], m_data[1], m_hdr[2], m_data[2]};
  endfunction

  function automatic logic [61:0] observed_vec();
    return {fc1_values_stored_o, fc2_values_stored_o, p_hdr_o, p_data_o,
            np_hdr_o, np_data_o, cpl_hdr_o, cpl_data_o};
  endfunction

  // Byte-wise CRC-16/0x100B with each byte reflected; returns the on-wire form.
  function automatic logic [15:0] ref_crc(input logic [31:0] w);
    logic [15:0] c;
    logic [7:0]  by, rev;
    c = 16'hFFFF;
    for (int b = 0; b < 4; b++) begin
      by = w[8*b +: 8];
      for (int k = 0; k < 8; k++) rev[k] = by[7-k];
      c = c ^ {rev, 8'h00};
      for (int k = 0; k < 8; k++) c = c[15] ? ((c << 1) ^ 16'h100B) : (c << 1);
    end
    return {~c[7:0], ~c[15:8]};
  endfunction

  function automatic logic [31:0] mk_dllp(input logic [3:0] kind, input logic [2:0] vc,
                                          input logic [7:0] h, input logic [11:0] d);
    logic [1:0] r1, r2;
    r1 = 2'($urandom_range(0, 3));
    r2 = 2'($urandom_range(0, 3));
    return {d[7:0], h[1:0], r2, d[11:8], r1, h[7:2], kind, 1'b0, vc};
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (crc_err_o === 1'b1) crc_err_seen++;
    if (update_valid_o === 1'b1) begin
      upd_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL update_unexpected got_type=%0d required=no_update", update_type_o);
      end else begin
        mon_exp = exp_q.pop_front();
        if (update_type_o !== mon_exp) begin
          failures++;
          $display("FAIL update_type got=%0d required=%0d", update_type_o, mon_exp);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    @(negedge clk);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tuser  = 3'($urandom_range(0, 7));
    @(posedge clk);
  endtask

  task automatic settle();
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic send_dllp(input logic [31:0] w, input logic corrupt);
    logic [15:0] c;
    c = ref_crc(w);
    if (corrupt) c = c ^ (16'h0001 << $urandom_range(0, 15));
    drive_beat(w, 4'hF, 1'b0);
    drive_beat({16'($urandom), c}, 4'h3, 1'b1);
  endtask

  task automatic send_fc(input logic [3:0] kind, input logic [2:0] vc,
                         input logic [7:0] h, input logic [11:0] d, input logic corrupt);
    send_dllp(mk_dllp(kind, vc, h, d), corrupt);
    if (!corrupt) model_apply(kind, vc, h, d);
  endtask

  task automatic pulse_dl_down();
    @(negedge clk);
    dl_down = 1'b1;
    @(negedge clk);
    dl_down = 1'b0;
    #1;
    model_clear();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    dl_down = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tdata = '0;
    s_axis_tkeep = '0;
    s_axis_tuser = '0;
    model_clear();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({s_axis_tready, update_valid_o, update_type_o, crc_err_o} !== 5'b0 || observed_vec() !== 62'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%h/%b required=0", observed_vec(), s_axis_tready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (s_axis_tready !== 1'b1) begin
      failures++;
      $display("FAIL tready_after_reset got=%b required=1", s_axis_tready);
    end
    checks++;
    if (observed_vec() !== model_vec()) begin
      failures++;
      $display("FAIL idle_after_reset got=%h required=%h", observed_vec(), model_vec());
    end
  endtask

  task automatic test_init_fc1();
    send_fc(4'h4, 3'd0, 8'h20, 12'h010, 1'b0);
    settle();
    send_fc(4'h5, 3'd0, 8'h20, 12'h000, 1'b0);
    settle();
    checks++;
    if (observed_vec() !== model_vec() || fc1_values_stored_o !== 1'b0) begin
      failures++;
      $display("FAIL init1_partial got=%h required=%h", observed_vec(), model_vec());
    end
    send_fc(4'h6, 3'd0, 8'h20, 12'h010, 1'b0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    #1;
    checks++;
    if (fc1_values_stored_o !== 1'b0) begin
      failures++;
      $display("FAIL fc1_latency_early got=%b required=0", fc1_values_stored_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (fc1_values_stored_o !== 1'b1) begin
      failures++;
      $display("FAIL fc1_stored got=%b required=1", fc1_values_stored_o);
    end
    checks++;
    if ({p_hdr_o, p_data_o, np_hdr_o, np_data_o, cpl_hdr_o, cpl_data_o} !== {8'h20, 12'h010, 8'h20, 12'h000, 8'h20, 12'h010}) begin
      failures++;
      $display("FAIL init1_credits got=%h required=%h", observed_vec(), model_vec());
    end
  endtask

  task automatic test_init_fc2();
    send_fc(4'hC, 3'd0, 8'h55, 12'h123, 1'b0);
    settle();
    checks++;
    if (fc2_values_stored_o !== 1'b1 || p_hdr_o !== 8'h20 || p_data_o !== 12'h010) begin
      failures++;
      $display("FAIL init2_frozen got=%b/%h/%h required=1/20/010", fc2_values_stored_o, p_hdr_o, p_data_o);
    end
    checks++;
    if (observed_vec() !== model_vec()) begin
      failures++;
      $display("FAIL init2_state got=%h required=%h", observed_vec(), model_vec());
    end
  endtask

  task automatic test_update_cpl_max();
    int u0;
    u0 = upd_seen;
    send_fc(4'hA, 3'd0, 8'($urandom_range(0, 255)), 12'hFFF, 1'b0);
    settle();
    checks++;
    if (cpl_data_o !== 12'hFFF) begin
      failures++;
      $display("FAIL update_cpl_data got=%h required=fff", cpl_data_o);
    end
    @(negedge clk);
    #1;
    checks++;
    if (upd_seen - u0 !== 1) begin
      failures++;
      $display("FAIL update_pulse_width got=%0d required=1", upd_seen - u0);
    end
  endtask

  // Random DLLP stream with gaps or back-to-back packets, bad CRCs, foreign VCs.
  task automatic test_random_mix(input int n);
    int e0, u0, exp_err, pushed;
    int sel;
    logic [3:0] kind;
    logic [2:0] vc;
    logic corrupt;
    e0 = crc_err_seen;
    u0 = upd_seen;
    exp_err = 0;
    pushed = 0;
    for (int i = 0; i < n; i++) begin
      sel = $urandom_range(0, 11);
      if (sel < 3)       kind = 4'(4 + sel);
      else if (sel < 6)  kind = 4'(12 + sel - 3);
      else if (sel < 9)  kind = 4'(8 + sel - 6);
      else if (sel == 9) kind = 4'h0;
      else if (sel == 10) kind = 4'h2;
      else               kind = 4'h3;
      vc = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      corrupt = ($urandom_range(0, 7) == 0);
      if (corrupt) exp_err++;
      pushed = pushed + 1;
      send_fc(kind, vc, 8'($urandom_range(0, 255)), 12'($urandom_range(0, 4095)), corrupt);
      if ($urandom_range(0, 1) == 1) begin
        settle();
        checks++;
        if (observed_vec() !== model_vec()) begin
          failures++;
          $display("FAIL random_state pkt=%0d got=%h required=%h", i, observed_vec(), model_vec());
        end
      end
    end
    settle();
    @(negedge clk);
    #1;
    checks++;
    if (observed_vec() !== model_vec()) begin
      failures++;
      $display("FAIL random_final got=%h required=%h", observed_vec(), model_vec());
    end
    checks++;
    if (crc_err_seen - e0 !== exp_err) begin
      failures++;
      $display("FAIL random_crc_errs got=%0d required=%0d", crc_err_seen - e0, exp_err);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL random_updates_missing got=%0d required=0 pending", exp_q.size());
    end
  endtask

  task automatic test_dl_down();
    pulse_dl_down();
    checks++;
    if (observed_vec() !== 62'b0) begin
      failures++;
      $display("FAIL dl_down_from_done got=%h required=0", observed_vec());
    end
    send_fc(4'h4, 3'd0, 8'($urandom_range(1, 255)), 12'($urandom_range(1, 4095)), 1'b0);
    send_fc(4'h5, 3'd0, 8'($urandom_range(1, 255)), 12'($urandom_range(1, 4095)), 1'b0);
    send_fc(4'h6, 3'd0, 8'($urandom_range(1, 255)), 12'($urandom_range(1, 4095)), 1'b0);
    settle();
    checks++;
    if (observed_vec() !== model_vec() || fc1_values_stored_o !== 1'b1) begin
      failures++;
      $display("FAIL reinit_fc1 got=%h required=%h", observed_vec(), model_vec());
    end
    pulse_dl_down();
    checks++;
    if (observed_vec() !== 62'b0) begin
      failures++;
      $display("FAIL dl_down_in_init2 got=%h required=0", observed_vec());
    end
  endtask

  task automatic test_dl_down_inflight();
    logic [31:0] w;
    int e0;
    e0 = crc_err_seen;
    w = mk_dllp(4'h4, 3'd0, 8'h33, 12'h444);
    drive_beat(w, 4'hF, 1'b0);
    @(negedge clk);
    dl_down = 1'b1;
    s_axis_tdata = {16'h0, ref_crc(w)};
    s_axis_tkeep = 4'h3;
    s_axis_tlast = 1'b1;
    @(posedge clk);
    @(negedge clk);
    dl_down = 1'b0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (observed_vec() !== 62'b0 || crc_err_seen != e0) begin
      failures++;
      $display("FAIL inflight_discard got=%h errs=%0d required=0 errs=0", observed_vec(), crc_err_seen - e0);
    end
  endtask

  task automatic test_bad_crc();
    int e0;
    e0 = crc_err_seen;
    send_fc(4'h5, 3'd0, 8'h20, 12'h000, 1'b1);
    settle();
    @(negedge clk);
    #1;
    checks++;
    if (crc_err_seen - e0 !== 1) begin
      failures++;
      $display("FAIL bad_crc_pulses got=%0d required=1", crc_err_seen - e0);
    end
    checks++;
    if (np_hdr_o !== 8'h00 || np_data_o !== 12'h000 || fc1_values_stored_o !== 1'b0) begin
      failures++;
      $display("FAIL bad_crc_state got=%h/%h/%b required=00/000/0", np_hdr_o, np_data_o, fc1_values_stored_o);
    end
  endtask

  task automatic test_malformed();
    logic [31:0] w;
    int e0;
    e0 = crc_err_seen;
    w = mk_dllp(4'h6, 3'd0, 8'h77, 12'h777);
    drive_beat(w, 4'hF, 1'b1);
    drive_beat(w, 4'hF, 1'b0);
    drive_beat({16'h0, ref_crc(w)}, 4'h3, 1'b0);
    drive_beat(32'($urandom), 4'h3, 1'b1);
    drive_beat(w, 4'h7, 1'b0);
    drive_beat({16'h0, ref_crc(w)}, 4'h3, 1'b1);
    settle();
    @(negedge clk);
    #1;
    checks++;
    if (crc_err_seen - e0 !== 3) begin
      failures++;
      $display("FAIL malformed_pulses got=%0d required=3", crc_err_seen - e0);
    end
    send_fc(4'h6, 3'd0, 8'h12, 12'h345, 1'b0);
    settle();
    checks++;
    if (observed_vec() !== model_vec() || cpl_hdr_o !== 8'h12) begin
      failures++;
      $display("FAIL malformed_recover got=%h required=%h", observed_vec(), model_vec());
    end
  endtask

  task automatic test_reset_mid_packet();
    drive_beat(mk_dllp(4'h4, 3'd0, 8'h99, 12'h999), 4'hF, 1'b0);
    @(negedge clk);
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    #1;
    model_clear();
    checks++;
    if (observed_vec() !== 62'b0 || s_axis_tready !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_packet got=%h/%b required=0/0", observed_vec(), s_axis_tready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_fc(4'h6, 3'd0, 8'h21, 12'h111, 1'b0);
    send_fc(4'h4, 3'd0, 8'h22, 12'h222, 1'b0);
    send_fc(4'h5, 3'd0, 8'h23, 12'h333, 1'b0);
    settle();
    checks++;
    if (observed_vec() !== model_vec() || fc1_values_stored_o !== 1'b1) begin
      failures++;
      $display("FAIL reinit_after_reset got=%h required=%h", observed_vec(), model_vec());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_init_fc1();
    test_init_fc2();
    test_update_cpl_max();
    test_random_mix(30);
    test_dl_down();
    test_dl_down_inflight();
    test_bad_crc();
    test_malformed();
    pulse_dl_down();
    test_random_mix(60);
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog got=timeout required=completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcie_flow_ctrl_rx.md
Name: pcie_flow_ctrl_rx

Overview:
Receive-side counterpart of the transmit flow-control init sequencer. It consumes received DLLPs from the DLLP receive path as a 32-bit AXI-Stream, checks the DLLP CRC, and decodes InitFC1, InitFC2 and UpdateFC for VC0. It latches the link partner's P/NP/Cpl header and data credits. It drives fc1_values_stored_o and fc2_values_stored_o, which feed the transmit init sequencer's fc1/fc2_values_stored inputs, and it reports UpdateFC credits to the TLP credit gate.

Parameters:
DATA_WIDTH, 32, stream width; only 32 is supported.
KEEP_WIDTH, DATA_WIDTH/8, tkeep width.
USER_WIDTH, 3, tuser width; tuser is ignored on input.

Ports:
clk_i  in  1  clock
rst_n_i  in  1  reset, synchronous, active-low
dl_down_i  in  1  link down; restarts FC init while held
s_axis_tdata  in  32  DLLP beat; byte0 in [7:0]
s_axis_tkeep  in  4  byte enables
s_axis_tvalid  in  1  beat valid
s_axis_tlast  in  1  last beat
s_axis_tuser  in  USER_WIDTH  ignored
s_axis_tready  out  1  always 1 outside reset
fc1_values_stored_o  out  1  all three InitFC types recorded
fc2_values_stored_o  out  1  FI2 reached
p_hdr_o, np_hdr_o, cpl_hdr_o  out  8 each  header credits (0 means infinite)
p_data_o, np_data_o, cpl_data_o  out  12 each  data credits (0 means infinite)
update_valid_o  out  1  one-cycle pulse on a good UpdateFC
update_type_o  out  2  0=P, 1=NP, 2=Cpl
crc_err_o  out  1  one-cycle pulse on a bad CRC or malformed DLLP

Behaviour:
- Reset (rst_n_i low at a clock edge) clears every register and output to 0, including s_axis_tready. A reset in the middle of a packet drops the partial DLLP.
- Packet format is two beats:
  - Beat 0: DLLP bytes 0-3. tkeep must be 0xF and tlast must be 0.
  - Beat 1: CRC in [15:0], as the transmitter emits it (inverted and byte-swapped). tkeep must be 0x3 and tlast must be 1.
- Packet FSM states:
  - RX_HDR: on a beat 0 with tlast=1, pulse crc_err_o and stay; otherwise register the beat and go to RX_CRC.
  - RX_CRC: on a beat with tlast=1, compare the CRC and go to RX_HDR; on tlast=0, pulse crc_err_o and go to RX_DRAIN.
  - RX_DRAIN: discard beats until tlast, then go to RX_HDR.
- CRC is pcie_datalink_crc over the registered beat 0 with crcIn=16'hFFFF. A DLLP is good when the CRC matches. The decode commits on the cycle after beat 1 is accepted, so outputs change one cycle after that.
- Field decode, byte0 = type:
  - Type[7:4]: 4/5/6 = InitFC1 P/NP/Cpl; C/D/E = InitFC2; 8/9/A = UpdateFC.
  - Type[2:0] = VC; any VC other than 0 is dropped silently.
  - Hdr = {byte1[5:0], byte2[7:6]}; Data = {byte2[3:0], byte3}.
  - Any other type (Ack, Nak, PM, vendor) is dropped silently.
- FC init FSM:
  - FC_INIT1: a good InitFC1 or InitFC2 stores its type's credits and sets that type's seen bit. When all three seen bits are set, assert fc1_values_stored_o and go to FC_INIT2.
  - FC_INIT2: credits are frozen. The first good InitFC2 or UpdateFC asserts fc2_values_stored_o and goes to FC_DONE. InitFC1 is ignored.
  - FC_DONE: a good UpdateFC overwrites its type's credits and pulses update_valid_o with update_type_o in the same cycle. InitFC DLLPs are ignored.
- dl_down_i=1 forces FC_INIT1, clears the seen bits, fc1/fc2_values_stored_o and all credits. An in-flight DLLP completing in that cycle is discarded.
- Duplicate InitFC1 of the same type in FC_INIT1 overwrites the earlier values; the last one wins.
- Both stored flags are level outputs and stay high until reset or dl_down_i.

Optional Feature:
PCIE_FC_RX_STATS_EN.
- Defined: adds outputs crc_err_cnt_o[15:0] and drop_cnt_o[15:0]. crc_err_cnt_o counts crc_err_o pulses; drop_cnt_o counts good DLLPs dropped for VC, type or state. Both saturate at 16'hFFFF and clear on reset or dl_down_i.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- pcie_datalink_pkg gains:
  - dllp_type_e encodings InitFC1_*, InitFC2_*, UpdateFC_*.
  - fc_type_e {FC_P, FC_NP, FC_CPL}.
  - A dllp_fc_t field accessor for Hdr/Data.
- The existing HdrMinCredits constant is shared with the transmit side.
- Sub-module: pcie_datalink_crc, instantiated once on the registered beat 0.

Test Plan:
1. Good InitFC1 P (Hdr=0x20, Data=0x010), NP (0x20/0x000), Cpl (0x20/0x010) -> fc1_values_stored_o=1 one cycle after the Cpl CRC beat; credits match.
2. After test 1, send InitFC2 P -> fc2_values_stored_o=1 and credits are unchanged even if the InitFC2 carries Hdr=0x55.
3. InitFC1 NP with a flipped CRC bit -> crc_err_o pulses once; np credits stay 0; fc1_values_stored_o stays 0.
4. Beat 0 with tlast=1, then three-beat packet -> crc_err_o pulses for each; FSM recovers and the next good DLLP is decoded.
5. In FC_DONE, UpdateFC Cpl with Data=0xFFF -> update_valid_o=1 and update_type_o=2 for exactly one cycle; cpl_data_o=0xFFF.
6. Assert dl_down_i mid-FC_INIT2, and separately pull rst_n_i low mid-packet -> all flags and credits go to 0; a full InitFC1 sequence then completes again.
